// File: rtl/c3lib_ckmux4_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : c3lib_ckmux4_sel_ctrl
// Brief    : Glitch-free select sequencer for a 4:1 clock mux and its
//            downstream clock gate. It gates the clock off, changes the
//            selects, waits for the mux to settle, then re-enables the gate
//            and acknowledges the requester.
// Revision : 1.0 - initial release
// ============================================================================
module c3lib_ckmux4_sel_ctrl #(
    parameter int GATE_OFF_CYC = 4,
    parameter int SETTLE_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel_req,
    input  logic       sel_req_vld,
    output logic       s0,
    output logic       s1,
    output logic       ck_gate_en,
    output logic       busy,
    output logic       sel_ack,
    output logic       req_drop,
    output logic [1:0] cur_sel
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_GATE_OFF = 2'd1;
    localparam logic [1:0] c_ST_SWITCH   = 2'd2;
    localparam logic [1:0] c_ST_SETTLE   = 2'd3;

    localparam logic [7:0] c_GATE_OFF_LD = 8'(GATE_OFF_CYC);
    localparam logic [7:0] c_SETTLE_LD   = 8'(SETTLE_CYC);

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_target;
    logic [1:0] r_sel;
    logic       r_gate_en;
    logic       r_busy;
    logic       r_ack;
    logic       r_drop;
    logic       r_boot;

    logic [1:0] w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] w_target_nxt;
    logic [1:0] w_sel_nxt;
    logic       w_gate_en_nxt;
    logic       w_busy_nxt;
    logic       w_ack_nxt;
    logic       w_drop_nxt;
    logic       w_boot_nxt;
    logic       w_cnt_last;

    // A count of 1 (or an out-of-range 0) ends the current wait phase.
    assign w_cnt_last = (r_cnt <= 8'd1);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_target_nxt  = r_target;
        w_sel_nxt     = r_sel;
        w_gate_en_nxt = r_gate_en;
        w_busy_nxt    = r_busy;
        w_ack_nxt     = 1'b0;
        w_drop_nxt    = 1'b0;
        w_boot_nxt    = r_boot;

        case (r_state)
            c_ST_IDLE: begin
                if (sel_req_vld) begin
                    if (sel_req == r_sel) begin
                        // Source already active: acknowledge without touching the mux.
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_target_nxt  = sel_req;
                        w_cnt_nxt     = c_GATE_OFF_LD;
                        w_state_nxt   = c_ST_GATE_OFF;
                        w_gate_en_nxt = 1'b0;
                        w_busy_nxt    = 1'b1;
                    end
                end
            end
            c_ST_GATE_OFF: begin
                w_drop_nxt = sel_req_vld;
                if (w_cnt_last) begin
                    // Selects move on entry to SWITCH, with the gate long closed.
                    w_state_nxt = c_ST_SWITCH;
                    w_sel_nxt   = r_target;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            c_ST_SWITCH: begin
                w_drop_nxt  = sel_req_vld;
                w_cnt_nxt   = c_SETTLE_LD;
                w_state_nxt = c_ST_SETTLE;
            end
            default: begin
                w_drop_nxt = sel_req_vld;
                if (w_cnt_last) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_gate_en_nxt = 1'b1;
                    w_busy_nxt    = 1'b0;
                    // The power-up settle has no requester to acknowledge.
                    w_ack_nxt     = ~r_boot;
                    w_boot_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
        endcase
    end

    // State and output registers; reset starts in the power-up settle phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_SETTLE;
            r_cnt     <= c_SETTLE_LD;
            r_target  <= 2'b00;
            r_sel     <= 2'b00;
            r_gate_en <= 1'b0;
            r_busy    <= 1'b1;
            r_ack     <= 1'b0;
            r_drop    <= 1'b0;
            r_boot    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_target  <= w_target_nxt;
            r_sel     <= w_sel_nxt;
            r_gate_en <= w_gate_en_nxt;
            r_busy    <= w_busy_nxt;
            r_ack     <= w_ack_nxt;
            r_drop    <= w_drop_nxt;
            r_boot    <= w_boot_nxt;
        end
    end

    assign s0         = r_sel[0];
    assign s1         = r_sel[1];
    assign cur_sel    = r_sel;
    assign ck_gate_en = r_gate_en;
    assign busy       = r_busy;
    assign sel_ack    = r_ack;
    assign req_drop   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_c3lib_ckmux4_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_c3lib_ckmux4_sel_ctrl
// Brief    : Self-checking bench for c3lib_ckmux4_sel_ctrl: a hand-written
//            vector table, reset and back-to-back corner sequences, and
//            random traffic against a timeline reference model, for the
//            default timing and for the minimum 1/1 timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c3lib_ckmux4_sel_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default timing (4/4). Instance B: minimum timing (1/1).
    logic       rst_n_a, vld_a, s0_a, s1_a, gate_a, busy_a, ack_a, drop_a;
    logic [1:0] req_a, cur_a;
    logic       rst_n_b, vld_b, s0_b, s1_b, gate_b, busy_b, ack_b, drop_b;
    logic [1:0] req_b, cur_b;

    c3lib_ckmux4_sel_ctrl #(.GATE_OFF_CYC(4), .SETTLE_CYC(4)) u_dut_dflt (
        .clk(clk), .rst_n(rst_n_a), .sel_req(req_a), .sel_req_vld(vld_a),
        .s0(s0_a), .s1(s1_a), .ck_gate_en(gate_a), .busy(busy_a),
        .sel_ack(ack_a), .req_drop(drop_a), .cur_sel(cur_a)
    );

    c3lib_ckmux4_sel_ctrl #(.GATE_OFF_CYC(1), .SETTLE_CYC(1)) u_dut_fast (
        .clk(clk), .rst_n(rst_n_b), .sel_req(req_b), .sel_req_vld(vld_b),
        .s0(s0_b), .s1(s1_b), .ck_gate_en(gate_b), .busy(busy_b),
        .sel_ack(ack_b), .req_drop(drop_b), .cur_sel(cur_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int dut_sel = 0;

    // Reference model: a timeline measured in edges since acceptance.
    int         m_g, m_s, m_k, m_end;
    bit         m_busy, m_boot, m_gate, m_ack, m_drop;
    logic [1:0] m_sel, m_tgt;
    logic [1:0] p_sel;
    logic       p_gate;

    // Output bundle: {sel[7:6], gate[5], busy[4], ack[3], drop[2], cur_sel[1:0]}
    function automatic logic [7:0] dut_out();
        if (dut_sel == 0) return {s1_a, s0_a, gate_a, busy_a, ack_a, drop_a, cur_a};
        else              return {s1_b, s0_b, gate_b, busy_b, ack_b, drop_b, cur_b};
    endfunction

    function automatic logic [7:0] model_out();
        return {m_sel, m_gate, m_busy, m_ack, m_drop, m_sel};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got sel=%b gate=%b busy=%b ack=%b drop=%b cur=%b, expected sel=%b gate=%b busy=%b ack=%b drop=%b cur=%b",
                     name, $time, act[7:6], act[5], act[4], act[3], act[2], act[1:0],
                     exp[7:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b1; m_boot = 1'b1; m_k = 0; m_end = m_s;
        m_sel = 2'b00; m_tgt = 2'b00; m_gate = 1'b0; m_ack = 1'b0; m_drop = 1'b0;
        p_sel = 2'b00; p_gate = 1'b0;
    endtask

    // Selects land G edges after acceptance; the sequence ends G+S+1 edges after it.
    task automatic model_step(input bit vld, input logic [1:0] req);
        m_ack = 1'b0; m_drop = 1'b0;
        if (m_busy) begin
            m_drop = vld;
            m_k++;
            if (!m_boot && m_k == m_g) m_sel = m_tgt;
            if (m_k == m_end) begin
                m_busy = 1'b0; m_gate = 1'b1; m_ack = ~m_boot; m_boot = 1'b0;
            end
        end else if (vld) begin
            if (req == m_sel) m_ack = 1'b1;
            else begin
                m_busy = 1'b1; m_k = 0; m_end = m_g + m_s + 1; m_tgt = req; m_gate = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit vld, input logic [1:0] req);
        if (dut_sel == 0) begin vld_a = vld; req_a = req; end
        else              begin vld_b = vld; req_b = req; end
    endtask

    // One clock: apply inputs, step the model on the edge, compare just after it.
    task automatic cycle(input bit vld, input logic [1:0] req, input string name,
                         output logic [7:0] act);
        drive(vld, req);
        @(posedge clk);
        model_step(vld, req);
        #1;
        act = dut_out();
        check(name, act, model_out());
        if (act[7:6] !== p_sel) begin
            n_vec++;
            if (p_gate !== 1'b0 || act[5] !== 1'b0) begin
                n_err++;
                $display("FAIL sel_change_gate @%0t: gate before=%b after=%b, required 0/0",
                         $time, p_gate, act[5]);
            end
        end
        p_sel = act[7:6];
        p_gate = act[5];
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #1;
        drive(1'b0, 2'b00);
        if (dut_sel == 0) rst_n_a = 1'b0; else rst_n_b = 1'b0;
        #1;
        check(name, dut_out(), 8'b00_0_1_0_0_00);
        @(posedge clk); @(posedge clk); #1;
        if (dut_sel == 0) rst_n_a = 1'b1; else rst_n_b = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         vld;
        logic [1:0] req;
        logic [1:0] sel;
        bit         gate, busy, ack, drop;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit vld, input logic [1:0] req, input logic [1:0] sel,
                       input bit gate, input bit busy, input bit ack, input bit drop);
        vec_t v;
        v.vld = vld; v.req = req; v.sel = sel;
        v.gate = gate; v.busy = busy; v.ack = ack; v.drop = drop;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] act;
        int         lat;
        logic [1:0] seq [4];

        rst_n_a = 1'b0; rst_n_b = 1'b0;
        vld_a = 1'b0; req_a = 2'b00; vld_b = 1'b0; req_b = 2'b00;

        // Hand-derived expectations for the default 4/4 instance.
        // Power-up settle: gate opens after the 4th edge, no ack.
        add(0,0, 0,0,1,0,0); add(0,0, 0,0,1,0,0); add(0,0, 0,0,1,0,0);
        add(0,0, 0,1,0,0,0);
        // Switch 0 -> 2 accepted at edge N.
        add(1,2, 0,0,1,0,0);
        add(0,0, 0,0,1,0,0); add(0,0, 0,0,1,0,0); add(0,0, 0,0,1,0,0);
        add(0,0, 2,0,1,0,0);                                   // N+4: selects move
        add(0,0, 2,0,1,0,0); add(0,0, 2,0,1,0,0); add(0,0, 2,0,1,0,0); add(0,0, 2,0,1,0,0);
        add(0,0, 2,1,0,1,0);                                   // N+9: ack
        // Same-source request in the ack cycle: acked one edge later.
        add(1,2, 2,1,0,1,0);
        add(0,0, 2,1,0,0,0);
        // Switch to 3 with a request for 1 dropped mid-sequence.
        add(1,3, 2,0,1,0,0);
        add(0,0, 2,0,1,0,0);
        add(1,1, 2,0,1,0,1);
        add(0,0, 2,0,1,0,0);
        add(0,0, 3,0,1,0,0);
        add(0,0, 3,0,1,0,0); add(0,0, 3,0,1,0,0); add(0,0, 3,0,1,0,0); add(0,0, 3,0,1,0,0);
        add(0,0, 3,1,0,1,0);
        add(0,0, 3,1,0,0,0); add(0,0, 3,1,0,0,0);              // no second ack

        m_g = 4; m_s = 4;
        dut_sel = 0;
        do_reset("reset_dflt");
        foreach (tbl[i]) begin
            cycle(tbl[i].vld, tbl[i].req, "model_dflt", act);
            check($sformatf("table_row%0d", i), act,
                  {tbl[i].sel, tbl[i].gate, tbl[i].busy, tbl[i].ack, tbl[i].drop, tbl[i].sel});
        end

        // Reset asserted during SWITCH (switch 3 -> 1, selects just moved).
        cycle(1'b1, 2'd1, "model_dflt", act);
        for (int k = 0; k < 4; k++) cycle(1'b0, 2'd0, "model_dflt", act);
        check("in_switch", act, 8'b01_0_1_0_0_01);
        #1;
        rst_n_a = 1'b0;
        #1;
        check("reset_mid_switch", dut_out(), 8'b00_0_1_0_0_00);
        @(posedge clk); #1;
        rst_n_a = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) cycle(1'b0, 2'd0, "repowerup", act);

        // Random traffic, default timing.
        for (int k = 0; k < 300; k++)
            cycle(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), "rand_dflt", act);
        drive(1'b0, 2'b00);

        // Minimum timing: cycle 0->1->2->3->0, ack exactly 3 edges after each request.
        dut_sel = 1;
        m_g = 1; m_s = 1;
        do_reset("reset_fast");
        cycle(1'b0, 2'd0, "model_fast", act);
        check("fast_powerup", act, 8'b00_1_0_0_0_00);
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
        for (int j = 0; j < 4; j++) begin
            cycle(1'b1, seq[j], "model_fast", act);
            lat = 0;
            for (int k = 1; k <= 5; k++) begin
                cycle(1'b0, 2'd0, "model_fast", act);
                if (act[3] === 1'b1) begin lat = k; break; end
            end
            check_int($sformatf("ack_latency_to_%0d", seq[j]), lat, 3);
            check_int($sformatf("cur_sel_is_%0d", seq[j]), int'(act[1:0]), int'(seq[j]));
        end

        // Random traffic, minimum timing.
        for (int k = 0; k < 200; k++)
            cycle(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), "rand_fast", act);
        drive(1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
